// File: rtl/mips_pkg.sv
// Shared MIPS definitions: control-vector layout, bubble constant and
// instruction field positions used by the decode/execute boundary.
package mips_pkg;

    localparam int CTRL_W   = 10;

    // Control vector: {regWrite, memRead, memWrite, memToReg, aluSrc, regDst, aluOp[3:0]}
    localparam int REGWRITE = 9;
    localparam int MEMREAD  = 8;
    localparam int MEMWRITE = 7;
    localparam int MEMTOREG = 6;
    localparam int ALUSRC   = 5;
    localparam int REGDST   = 4;
    localparam int ALUOP_HI = 3;
    localparam int ALUOP_LO = 0;

    localparam logic [CTRL_W-1:0] CTRL_BUBBLE = 10'b0;

    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection between the load in EX and the instruction in ID,
// plus the PC / IF-ID write enables that hold the front end during a stall.
module hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              exMemRead,
    input  logic [REG_AW-1:0] exRt,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic              flush,
    output logic              hazard,
    output logic              pc_write,
    output logic              ifid_write
);

    assign hazard = exMemRead && (exRt != '0) && ((exRt == idRs) || (exRt == idRt));

    // A redirect must still write the PC, so flush overrides the stall.
    assign pc_write   = !(hazard && !flush);
    assign ifid_write = !(hazard && !flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline boundary: field decode, writeback bypass around the register
// file, load-use bubble insertion and a saturating stall counter.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_id,
    input  logic [31:0]       pc4_id,
    input  logic [9:0]        ctrl_id,
    input  logic [DATA_W-1:0] rf_readData1,
    input  logic [DATA_W-1:0] rf_readData2,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_writeReg,
    input  logic [DATA_W-1:0] wb_writeData,
    input  logic              flush,
    output logic              pc_write,
    output logic              ifid_write,
    output logic [9:0]        ctrl_ex,
    output logic [31:0]       pc4_ex,
    output logic [DATA_W-1:0] rs_data_ex,
    output logic [DATA_W-1:0] rt_data_ex,
    output logic [DATA_W-1:0] imm_ex,
    output logic [4:0]        shamt_ex,
    output logic [REG_AW-1:0] rs_ex,
    output logic [REG_AW-1:0] rt_ex,
    output logic [REG_AW-1:0] dest_ex,
    output logic [31:0]       stall_count
);

    logic [REG_AW-1:0] rsId;
    logic [REG_AW-1:0] rtId;
    logic [REG_AW-1:0] rdId;
    logic [4:0]        shamtId;
    logic [15:0]       immId;
    logic [REG_AW-1:0] destId;
    logic [DATA_W-1:0] rsVal;
    logic [DATA_W-1:0] rtVal;
    logic              hazard;
    logic              unusedOpcode;

    assign rsId    = instr_id[RS_HI:RS_LO];
    assign rtId    = instr_id[RT_HI:RT_LO];
    assign rdId    = instr_id[RD_HI:RD_LO];
    assign shamtId = instr_id[SHAMT_HI:SHAMT_LO];
    assign immId   = instr_id[IMM_HI:IMM_LO];
    assign destId  = ctrl_id[REGDST] ? rdId : rtId;

    // Opcode is already decoded into ctrl_id upstream.
    assign unusedOpcode = &{1'b0, instr_id[31:26]};

    // The register file does not return a same-edge write, so forward WB here.
    assign rsVal = (wb_regWrite && (wb_writeReg != '0) && (wb_writeReg == rsId))
                   ? wb_writeData : rf_readData1;
    assign rtVal = (wb_regWrite && (wb_writeReg != '0) && (wb_writeReg == rtId))
                   ? wb_writeData : rf_readData2;

    hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .exMemRead  (ctrl_ex[MEMREAD]),
        .exRt       (rt_ex),
        .idRs       (rsId),
        .idRt       (rtId),
        .flush      (flush),
        .hazard     (hazard),
        .pc_write   (pc_write),
        .ifid_write (ifid_write)
    );

    always_ff @(posedge clk) begin
        if (rst || flush || hazard) begin
            ctrl_ex    <= CTRL_BUBBLE;
            pc4_ex     <= '0;
            rs_data_ex <= '0;
            rt_data_ex <= '0;
            imm_ex     <= '0;
            shamt_ex   <= '0;
            rs_ex      <= '0;
            rt_ex      <= '0;
            dest_ex    <= '0;
        end else begin
            ctrl_ex    <= ctrl_id;
            pc4_ex     <= pc4_id;
            rs_data_ex <= rsVal;
            rt_data_ex <= rtVal;
            imm_ex     <= {{(DATA_W-16){immId[15]}}, immId};
            shamt_ex   <= shamtId;
            rs_ex      <= rsId;
            rt_ex      <= rtId;
            dest_ex    <= destId;
        end
    end

    // Only stalls that actually hold the front end are counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && !flush && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, decode, WB bypass, load-use
// stall, flush priority, immediate decode and reset during a stall.
module tb_id_ex_stage;

    localparam logic [31:0] I_ADD   = 32'h0022_1820; // add $3,$1,$2
    localparam logic [31:0] I_ADD0  = 32'h0002_1820; // add $3,$0,$2
    localparam logic [31:0] I_LW    = 32'h8C24_0000; // lw  $4,0($1)
    localparam logic [31:0] I_ADDU  = 32'h0082_2820; // add $5,$4,$2
    localparam logic [31:0] I_ADDI  = 32'h2002_FFFC; // addi $2,$0,-4
    localparam logic [9:0]  C_RTYPE = 10'h212;
    localparam logic [9:0]  C_LW    = 10'h360;
    localparam logic [9:0]  C_ADDI  = 10'h220;

    logic        clk;
    logic        rst;
    logic [31:0] instr_id;
    logic [31:0] pc4_id;
    logic [9:0]  ctrl_id;
    logic [31:0] rf_readData1;
    logic [31:0] rf_readData2;
    logic        wb_regWrite;
    logic [4:0]  wb_writeReg;
    logic [31:0] wb_writeData;
    logic        flush;
    logic        pc_write;
    logic        ifid_write;
    logic [9:0]  ctrl_ex;
    logic [31:0] pc4_ex;
    logic [31:0] rs_data_ex;
    logic [31:0] rt_data_ex;
    logic [31:0] imm_ex;
    logic [4:0]  shamt_ex;
    logic [4:0]  rs_ex;
    logic [4:0]  rt_ex;
    logic [4:0]  dest_ex;
    logic [31:0] stall_count;

    int checks;
    int errors;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .instr_id     (instr_id),
        .pc4_id       (pc4_id),
        .ctrl_id      (ctrl_id),
        .rf_readData1 (rf_readData1),
        .rf_readData2 (rf_readData2),
        .wb_regWrite  (wb_regWrite),
        .wb_writeReg  (wb_writeReg),
        .wb_writeData (wb_writeData),
        .flush        (flush),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ctrl_ex      (ctrl_ex),
        .pc4_ex       (pc4_ex),
        .rs_data_ex   (rs_data_ex),
        .rt_data_ex   (rt_data_ex),
        .imm_ex       (imm_ex),
        .shamt_ex     (shamt_ex),
        .rs_ex        (rs_ex),
        .rt_ex        (rt_ex),
        .dest_ex      (dest_ex),
        .stall_count  (stall_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge
    task automatic drive_id(input logic [31:0] instr, input logic [9:0] ctrl,
                            input logic [31:0] pc4, input logic [31:0] rd1,
                            input logic [31:0] rd2);
        @(negedge clk);
        instr_id     = instr;
        ctrl_id      = ctrl;
        pc4_id       = pc4;
        rf_readData1 = rd1;
        rf_readData2 = rd2;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] reg_idx, input logic [31:0] data);
        wb_regWrite  = we;
        wb_writeReg  = reg_idx;
        wb_writeData = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(I_ADD, C_RTYPE, 32'h100, 32'h5, 32'h7);
        tick();
        tick();
        checks++;
        if ({ctrl_ex, pc4_ex, rs_data_ex, rt_data_ex, imm_ex} !== '0) begin
            errors++;
            $display("FAIL reset_data got ctrl=%h pc4=%h rs=%h rt=%h imm=%h want all 0",
                     ctrl_ex, pc4_ex, rs_data_ex, rt_data_ex, imm_ex);
        end
        checks++;
        if ({shamt_ex, rs_ex, rt_ex, dest_ex, stall_count} !== '0) begin
            errors++;
            $display("FAIL reset_idx got shamt=%h rs=%h rt=%h dest=%h cnt=%h want all 0",
                     shamt_ex, rs_ex, rt_ex, dest_ex, stall_count);
        end
        checks++;
        if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_enables got pc_write=%b ifid_write=%b want 1 1", pc_write, ifid_write);
        end
    endtask

    task automatic test_decode();
        drive_id(I_ADD, C_RTYPE, 32'h104, 32'h5, 32'h7);
        rst = 1'b0;
        tick();
        checks++;
        if (rs_data_ex !== 32'h5 || rt_data_ex !== 32'h7) begin
            errors++;
            $display("FAIL decode_data got rs=%h rt=%h want 5 7", rs_data_ex, rt_data_ex);
        end
        checks++;
        if (dest_ex !== 5'd3 || ctrl_ex !== C_RTYPE || pc4_ex !== 32'h104) begin
            errors++;
            $display("FAIL decode_ctrl got dest=%0d ctrl=%h pc4=%h want 3 212 104", dest_ex, ctrl_ex, pc4_ex);
        end
        checks++;
        if (rs_ex !== 5'd1 || rt_ex !== 5'd2 || shamt_ex !== 5'd0 || imm_ex !== 32'h0000_1820) begin
            errors++;
            $display("FAIL decode_fields got rs=%0d rt=%0d shamt=%0d imm=%h want 1 2 0 00001820",
                     rs_ex, rt_ex, shamt_ex, imm_ex);
        end
    endtask

    task automatic test_bypass();
        drive_id(I_ADD, C_RTYPE, 32'h108, 32'h5, 32'h7);
        drive_wb(1'b1, 5'd1, 32'h0000_DEAD);
        tick();
        checks++;
        if (rs_data_ex !== 32'h0000_DEAD || rt_data_ex !== 32'h7) begin
            errors++;
            $display("FAIL bypass_rs got rs=%h rt=%h want 0000dead 7", rs_data_ex, rt_data_ex);
        end
        drive_id(I_ADD, C_RTYPE, 32'h10C, 32'h5, 32'h7);
        drive_wb(1'b1, 5'd2, 32'h0000_BEEF);
        tick();
        checks++;
        if (rs_data_ex !== 32'h5 || rt_data_ex !== 32'h0000_BEEF) begin
            errors++;
            $display("FAIL bypass_rt got rs=%h rt=%h want 5 0000beef", rs_data_ex, rt_data_ex);
        end
        // Writes to register 0 must never be forwarded
        drive_id(I_ADD0, C_RTYPE, 32'h110, 32'h0, 32'h7);
        drive_wb(1'b1, 5'd0, 32'h0000_DEAD);
        tick();
        checks++;
        if (rs_data_ex !== 32'h0) begin
            errors++;
            $display("FAIL bypass_r0 got rs=%h want 0", rs_data_ex);
        end
        drive_id(I_ADD, C_RTYPE, 32'h114, 32'h5, 32'h7);
        drive_wb(1'b0, 5'd1, 32'h0000_DEAD);
        tick();
        checks++;
        if (rs_data_ex !== 32'h5) begin
            errors++;
            $display("FAIL bypass_disabled got rs=%h want 5", rs_data_ex);
        end
    endtask

    task automatic test_load_use();
        drive_wb(1'b0, 5'd0, 32'h0);
        drive_id(I_LW, C_LW, 32'h200, 32'h40, 32'h0);
        tick();
        drive_id(I_ADDU, C_RTYPE, 32'h204, 32'h9, 32'h7);
        #1;
        checks++;
        if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            errors++;
            $display("FAIL loaduse_stall got pc_write=%b ifid_write=%b want 0 0", pc_write, ifid_write);
        end
        tick();
        checks++;
        if (ctrl_ex !== 10'h0 || dest_ex !== 5'd0 || rs_ex !== 5'd0 || rt_ex !== 5'd0) begin
            errors++;
            $display("FAIL loaduse_bubble got ctrl=%h dest=%0d rs=%0d rt=%0d want 0", ctrl_ex, dest_ex, rs_ex, rt_ex);
        end
        checks++;
        if (stall_count !== 32'd1 || pc_write !== 1'b1) begin
            errors++;
            $display("FAIL loaduse_count got cnt=%0d pc_write=%b want 1 1", stall_count, pc_write);
        end
        tick();
        checks++;
        if (ctrl_ex !== C_RTYPE || dest_ex !== 5'd5 || rs_ex !== 5'd4 || rs_data_ex !== 32'h9) begin
            errors++;
            $display("FAIL loaduse_release got ctrl=%h dest=%0d rs=%0d rsd=%h want 212 5 4 9",
                     ctrl_ex, dest_ex, rs_ex, rs_data_ex);
        end
    endtask

    task automatic test_flush_hazard();
        drive_id(I_LW, C_LW, 32'h300, 32'h40, 32'h0);
        tick();
        drive_id(I_ADDU, C_RTYPE, 32'h304, 32'h9, 32'h7);
        flush = 1'b1;
        #1;
        checks++;
        if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin
            errors++;
            $display("FAIL flush_enables got pc_write=%b ifid_write=%b want 1 1", pc_write, ifid_write);
        end
        tick();
        checks++;
        if (ctrl_ex !== 10'h0 || dest_ex !== 5'd0 || stall_count !== 32'd1) begin
            errors++;
            $display("FAIL flush_bubble got ctrl=%h dest=%0d cnt=%0d want 0 0 1", ctrl_ex, dest_ex, stall_count);
        end
        // Plain flush with no hazard present still squashes
        drive_id(I_ADD, C_RTYPE, 32'h308, 32'h5, 32'h7);
        tick();
        checks++;
        if (ctrl_ex !== 10'h0 || dest_ex !== 5'd0 || rs_ex !== 5'd0) begin
            errors++;
            $display("FAIL flush_plain got ctrl=%h dest=%0d rs=%0d want 0", ctrl_ex, dest_ex, rs_ex);
        end
        flush = 1'b0;
    endtask

    task automatic test_bypass_hazard();
        drive_id(I_LW, C_LW, 32'h400, 32'h40, 32'h0);
        tick();
        drive_id(I_ADDU, C_RTYPE, 32'h404, 32'h1, 32'h7);
        drive_wb(1'b1, 5'd4, 32'h0000_AAAA);
        tick();
        checks++;
        if (ctrl_ex !== 10'h0 || stall_count !== 32'd2) begin
            errors++;
            $display("FAIL byphaz_bubble got ctrl=%h cnt=%0d want 0 2", ctrl_ex, stall_count);
        end
        drive_id(I_ADDU, C_RTYPE, 32'h404, 32'h0000_AAAA, 32'h7);
        drive_wb(1'b0, 5'd0, 32'h0);
        tick();
        checks++;
        if (rs_data_ex !== 32'h0000_AAAA || dest_ex !== 5'd5) begin
            errors++;
            $display("FAIL byphaz_reread got rs=%h dest=%0d want 0000aaaa 5", rs_data_ex, dest_ex);
        end
    endtask

    task automatic test_immediate();
        drive_id(I_ADDI, C_ADDI, 32'h500, 32'h0, 32'h3);
        tick();
        checks++;
        if (imm_ex !== 32'hFFFF_FFFC || dest_ex !== 5'd2 || rt_ex !== 5'd2 || rs_ex !== 5'd0) begin
            errors++;
            $display("FAIL imm_addi got imm=%h dest=%0d rt=%0d rs=%0d want fffffffc 2 2 0",
                     imm_ex, dest_ex, rt_ex, rs_ex);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_id(I_LW, C_LW, 32'h600, 32'h40, 32'h0);
        tick();
        drive_id(I_ADDU, C_RTYPE, 32'h604, 32'h9, 32'h7);
        rst = 1'b1;
        tick();
        checks++;
        if (ctrl_ex !== 10'h0 || stall_count !== 32'd0 || pc4_ex !== 32'h0) begin
            errors++;
            $display("FAIL rststall_clear got ctrl=%h cnt=%0d pc4=%h want 0 0 0", ctrl_ex, stall_count, pc4_ex);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if (ctrl_ex !== C_RTYPE || dest_ex !== 5'd5 || pc4_ex !== 32'h604 || stall_count !== 32'd0) begin
            errors++;
            $display("FAIL rststall_resume got ctrl=%h dest=%0d pc4=%h cnt=%0d want 212 5 604 0",
                     ctrl_ex, dest_ex, pc4_ex, stall_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_decode();
        test_bypass();
        test_load_use();
        test_flush_hazard();
        test_bypass_hazard();
        test_immediate();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
